// File: rtl/ripple_count_monitor.sv
// Monitor for an asynchronous ripple counter: synchronise + filter the raw bus, check each
// accepted step, count wraps and expose a coherent req/ack snapshot.
// Optional build macro RIPPLE_MON_UP_COUNT_EN switches step/wrap checking to an up-counter.
module ripple_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int WRAP_W        = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        count_in,
    input  logic                    enable,
    input  logic                    err_clr,
    input  logic                    snap_req,
    input  logic                    snap_ack,
    output logic [WIDTH-1:0]        cur_count,
    output logic [WRAP_W-1:0]       wrap_cnt,
    output logic                    wrap_pulse,
    output logic                    wrap_ovf,
    output logic                    err,
    output logic                    snap_valid,
    output logic [WRAP_W+WIDTH-1:0] snap_data,
    output logic [1:0]              state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [3:0]        STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    function automatic logic is_wrap(input logic [WIDTH-1:0] prev, input logic [WIDTH-1:0] nxt);
`ifdef RIPPLE_MON_UP_COUNT_EN
        is_wrap = (prev == CNT_MAX) && (nxt == '0);
`else
        is_wrap = (prev == '0) && (nxt == CNT_MAX);
`endif
    endfunction

    function automatic logic is_step(input logic [WIDTH-1:0] prev, input logic [WIDTH-1:0] nxt);
`ifdef RIPPLE_MON_UP_COUNT_EN
        is_step = (nxt == (prev + CNT_ONE)) && !is_wrap(prev, nxt);
`else
        is_step = (nxt == (prev - CNT_ONE)) && !is_wrap(prev, nxt);
`endif
    endfunction

    state_t              state_r, state_nxt_s;
    logic [WIDTH-1:0]    sync1_r, sync2_r;
    logic [3:0]          stab_r;
    logic [WIDTH-1:0]    cur_count_r, cur_nxt_s;
    logic [WRAP_W-1:0]   wrap_cnt_r, wrap_cnt_nxt_s;
    logic                wrap_pulse_r, wrap_pulse_nxt_s;
    logic                wrap_ovf_r, wrap_ovf_nxt_s;
    logic                err_r, err_nxt_s;
    logic                snap_valid_r;
    logic [WRAP_W+WIDTH-1:0] snap_data_r;
    logic                reach_s, accept_s;

    // sync1 == sync2 means sync2 will not change at this edge, so stab_r counts unchanged cycles.
    assign reach_s  = (sync1_r == sync2_r) && (stab_r == (STAB_MAX - 4'd1));
    assign accept_s = reach_s && ((sync2_r != cur_count_r) || (state_r == ARM));

    // Two-flop synchroniser and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            stab_r  <= 4'd0;
        end else begin
            sync1_r <= count_in;
            sync2_r <= sync1_r;
            if (sync1_r != sync2_r) begin
                stab_r <= 4'd0;
            end else if (stab_r == STAB_MAX) begin
                stab_r <= STAB_MAX;
            end else begin
                stab_r <= stab_r + 4'd1;
            end
        end
    end

    // Next-state and tracking datapath.
    always_comb begin
        state_nxt_s      = state_r;
        cur_nxt_s        = cur_count_r;
        wrap_cnt_nxt_s   = wrap_cnt_r;
        wrap_ovf_nxt_s   = wrap_ovf_r;
        wrap_pulse_nxt_s = 1'b0;
        err_nxt_s        = err_r;
        if (!enable) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_nxt_s = ARM;
                ARM: begin
                    wrap_cnt_nxt_s = '0;
                    wrap_ovf_nxt_s = 1'b0;
                    if (accept_s) begin
                        cur_nxt_s   = sync2_r;
                        state_nxt_s = TRACK;
                    end else begin
                        state_nxt_s = ARM;
                    end
                end
                TRACK: begin
                    if (accept_s) begin
                        cur_nxt_s = sync2_r;
                        if (is_wrap(cur_count_r, sync2_r)) begin
                            wrap_pulse_nxt_s = 1'b1;
                            if (wrap_cnt_r == WRAP_MAX) begin
                                wrap_ovf_nxt_s = 1'b1;
                            end else begin
                                wrap_cnt_nxt_s = wrap_cnt_r + WRAP_ONE;
                            end
                        end else if (is_step(cur_count_r, sync2_r)) begin
                            state_nxt_s = TRACK;
                        end else begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = ERR;
                        end
                    end else begin
                        state_nxt_s = TRACK;
                    end
                end
                ERR: begin
                    if (accept_s) begin
                        cur_nxt_s = sync2_r;
                    end else begin
                        cur_nxt_s = cur_count_r;
                    end
                    if (err_clr) begin
                        err_nxt_s   = 1'b0;
                        state_nxt_s = ARM;
                    end else begin
                        state_nxt_s = ERR;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM and tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cur_count_r  <= '0;
            wrap_cnt_r   <= '0;
            wrap_pulse_r <= 1'b0;
            wrap_ovf_r   <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cur_count_r  <= cur_nxt_s;
            wrap_cnt_r   <= wrap_cnt_nxt_s;
            wrap_pulse_r <= wrap_pulse_nxt_s;
            wrap_ovf_r   <= wrap_ovf_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    // Snapshot: captures pre-update values, holds until acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_valid_r <= 1'b0;
            snap_data_r  <= '0;
        end else if (snap_valid_r) begin
            snap_valid_r <= !snap_ack;
        end else if (snap_req) begin
            snap_valid_r <= 1'b1;
            snap_data_r  <= {wrap_cnt_r, cur_count_r};
        end else begin
            snap_valid_r <= 1'b0;
        end
    end

    assign cur_count  = cur_count_r;
    assign wrap_cnt   = wrap_cnt_r;
    assign wrap_pulse = wrap_pulse_r;
    assign wrap_ovf   = wrap_ovf_r;
    assign err        = err_r;
    assign snap_valid = snap_valid_r;
    assign snap_data  = snap_data_r;
    assign state      = state_r;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: main instance (WRAP_W=8) plus a WRAP_W=2
// instance for wrap-counter saturation.
module tb_ripple_count_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  count_in, count_in2;
    logic        enable, enable2, err_clr, snap_req, snap_ack;

    logic [3:0]  cur_count, cur_count2;
    logic [7:0]  wrap_cnt;
    logic [1:0]  wrap_cnt2;
    logic        wrap_pulse, wrap_ovf, err, snap_valid;
    logic        wrap_pulse2, wrap_ovf2, err2, snap_valid2;
    logic [11:0] snap_data;
    logic [5:0]  snap_data2;
    logic [1:0]  state, state2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ripple_count_monitor #(.WIDTH(4), .WRAP_W(8), .STABLE_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .count_in(count_in), .enable(enable), .err_clr(err_clr),
        .snap_req(snap_req), .snap_ack(snap_ack), .cur_count(cur_count), .wrap_cnt(wrap_cnt),
        .wrap_pulse(wrap_pulse), .wrap_ovf(wrap_ovf), .err(err), .snap_valid(snap_valid),
        .snap_data(snap_data), .state(state)
    );

    ripple_count_monitor #(.WIDTH(4), .WRAP_W(2), .STABLE_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .count_in(count_in2), .enable(enable2), .err_clr(1'b0),
        .snap_req(1'b0), .snap_ack(1'b0), .cur_count(cur_count2), .wrap_cnt(wrap_cnt2),
        .wrap_pulse(wrap_pulse2), .wrap_ovf(wrap_ovf2), .err(err2), .snap_valid(snap_valid2),
        .snap_data(snap_data2), .state(state2)
    );

    // Drive one value and hold it for six cycles (enough for acceptance).
    task automatic step(input int which, input logic [3:0] v);
        @(negedge clk);
        if (which == 0) count_in = v;
        else count_in2 = v;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic down(input int which, input int n);
        logic [3:0] nv;
        for (int i = 0; i < n; i++) begin
            nv = (which == 0) ? count_in : count_in2;
            nv = nv - 4'd1;
            step(which, nv);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({cur_count, wrap_cnt, wrap_pulse, wrap_ovf, err, snap_valid, snap_data, state} !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got cur=%0d wrap=%0d err=%0b sv=%0b sd=%h st=%0d, expected all 0",
                     cur_count, wrap_cnt, err, snap_valid, snap_data, state);
        end
        tests_run++;
        if (state2 !== 2'd0 || cur_count2 !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_dut2: got st=%0d cur=%0d, expected 0 0", state2, cur_count2);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_track;
        logic [3:0] v, prev;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL enable_arm: got state %0d, expected 1", state);
        end
        for (int k = 0; k < 3; k++) begin
            v = 4'd5 - 4'(k);
            prev = (k == 0) ? 4'd0 : v + 4'd1;
            @(negedge clk);
            count_in = v;
            repeat (3) @(posedge clk);
            #1;
            tests_run++;
            if (cur_count !== prev || state !== ((k == 0) ? 2'd1 : 2'd2)) begin
                tests_failed++;
                $display("FAIL track_latency_early: got cur=%0d st=%0d, expected cur=%0d", cur_count, state, prev);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (cur_count !== v || state !== 2'd2 || err !== 1'b0) begin
                tests_failed++;
                $display("FAIL track_edge4: got cur=%0d st=%0d err=%0b, expected cur=%0d st=2 err=0",
                         cur_count, state, err, v);
            end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wrap;
        int pulses;
        pulses = 0;
        step(0, 4'd2);
        step(0, 4'd1);
        step(0, 4'd0);
        tests_run++;
        if (cur_count !== 4'd0 || wrap_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_pre: got cur=%0d wrap=%0d, expected 0 0", cur_count, wrap_cnt);
        end
        @(negedge clk);
        count_in = 4'd15;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (wrap_pulse) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL wrap_pulse_early: got %0d pulses, expected 0", pulses);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (wrap_pulse !== 1'b1 || cur_count !== 4'd15 || wrap_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL wrap_pulse_on: got pulse=%0b cur=%0d wrap=%0d, expected 1 15 1",
                     wrap_pulse, cur_count, wrap_cnt);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (wrap_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_pulse_width: got %0b, expected 0", wrap_pulse);
        end
        repeat (3) @(posedge clk);
        step(0, 4'd14);
        tests_run++;
        if (cur_count !== 4'd14 || wrap_cnt !== 8'd1 || err !== 1'b0 || state !== 2'd2) begin
            tests_failed++;
            $display("FAIL wrap_post: got cur=%0d wrap=%0d err=%0b st=%0d, expected 14 1 0 2",
                     cur_count, wrap_cnt, err, state);
        end
    endtask

    task automatic test_glitch_err;
        down(0, 6);
        @(negedge clk);
        count_in = 4'b0111;
        @(negedge clk);
        count_in = 4'd8;
        repeat (6) @(posedge clk);
        #1;
        tests_run++;
        if (cur_count !== 4'd8 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_reject: got cur=%0d err=%0b, expected 8 0", cur_count, err);
        end
        step(0, 4'd7);
        tests_run++;
        if (cur_count !== 4'd7 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_then_step: got cur=%0d err=%0b, expected 7 0", cur_count, err);
        end
        step(0, 4'd4);
        tests_run++;
        if (err !== 1'b1 || state !== 2'd3 || cur_count !== 4'd4) begin
            tests_failed++;
            $display("FAIL illegal_step: got err=%0b st=%0d cur=%0d, expected 1 3 4", err, state, cur_count);
        end
        step(0, 4'd9);
        tests_run++;
        if (cur_count !== 4'd9 || err !== 1'b1 || state !== 2'd3) begin
            tests_failed++;
            $display("FAIL err_tracks: got cur=%0d err=%0b st=%0d, expected 9 1 3", cur_count, err, state);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (state !== 2'd1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clr: got st=%0d err=%0b, expected 1 0", state, err);
        end
        @(negedge clk);
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (wrap_cnt !== 8'd0 || state !== 2'd1) begin
            tests_failed++;
            $display("FAIL arm_clears_wrap: got wrap=%0d st=%0d, expected 0 1", wrap_cnt, state);
        end
    endtask

    task automatic test_snapshot;
        down(0, 1);
        tests_run++;
        if (cur_count !== 4'd8 || state !== 2'd2) begin
            tests_failed++;
            $display("FAIL rearm_first: got cur=%0d st=%0d, expected 8 2", cur_count, state);
        end
        down(0, 34);
        tests_run++;
        if (cur_count !== 4'd6 || wrap_cnt !== 8'd2 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_pre: got cur=%0d wrap=%0d err=%0b, expected 6 2 0", cur_count, wrap_cnt, err);
        end
        @(negedge clk);
        snap_req = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (snap_valid !== 1'b1 || snap_data !== 12'h026) begin
            tests_failed++;
            $display("FAIL snap_capture: got valid=%0b data=%h, expected 1 026", snap_valid, snap_data);
        end
        down(0, 7);
        tests_run++;
        if (wrap_cnt !== 8'd3 || cur_count !== 4'd15 || snap_valid !== 1'b1 || snap_data !== 12'h026) begin
            tests_failed++;
            $display("FAIL snap_hold: got wrap=%0d cur=%0d valid=%0b data=%h, expected 3 15 1 026",
                     wrap_cnt, cur_count, snap_valid, snap_data);
        end
        @(negedge clk);
        snap_ack = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (snap_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL snap_ack: got valid=%0b, expected 0", snap_valid);
        end
        @(negedge clk);
        snap_ack = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (snap_valid !== 1'b1 || snap_data !== 12'h03F) begin
            tests_failed++;
            $display("FAIL snap_recapture: got valid=%0b data=%h, expected 1 03f", snap_valid, snap_data);
        end
        @(negedge clk);
        snap_req = 1'b0;
        snap_ack = 1'b1;
        @(negedge clk);
        snap_ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        down(0, 6);
        tests_run++;
        if (cur_count !== 4'd9 || wrap_cnt !== 8'd3 || state !== 2'd2) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got cur=%0d wrap=%0d st=%0d, expected 9 3 2", cur_count, wrap_cnt, state);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({cur_count, wrap_cnt, wrap_pulse, wrap_ovf, err, snap_valid, snap_data, state} !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got cur=%0d wrap=%0d err=%0b sv=%0b sd=%h st=%0d, expected all 0",
                     cur_count, wrap_cnt, err, snap_valid, snap_data, state);
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wrap_ovf;
        @(negedge clk);
        enable2 = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (state2 !== 2'd1) begin
            tests_failed++;
            $display("FAIL ovf_arm: got state %0d, expected 1", state2);
        end
        step(1, 4'd3);
        down(1, 4);
        tests_run++;
        if (wrap_cnt2 !== 2'd1 || cur_count2 !== 4'd15) begin
            tests_failed++;
            $display("FAIL ovf_wrap1: got wrap=%0d cur=%0d, expected 1 15", wrap_cnt2, cur_count2);
        end
        down(1, 32);
        tests_run++;
        if (wrap_cnt2 !== 2'd3 || wrap_ovf2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_wrap3: got wrap=%0d ovf=%0b, expected 3 0", wrap_cnt2, wrap_ovf2);
        end
        down(1, 16);
        tests_run++;
        if (wrap_cnt2 !== 2'd3 || wrap_ovf2 !== 1'b1 || err2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_wrap4: got wrap=%0d ovf=%0b err=%0b, expected 3 1 0", wrap_cnt2, wrap_ovf2, err2);
        end
    endtask

    task automatic test_disable;
        @(negedge clk);
        enable2 = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (state2 !== 2'd0 || wrap_cnt2 !== 2'd3 || wrap_ovf2 !== 1'b1 || cur_count2 !== 4'd15) begin
            tests_failed++;
            $display("FAIL disable_idle: got st=%0d wrap=%0d ovf=%0b cur=%0d, expected 0 3 1 15",
                     state2, wrap_cnt2, wrap_ovf2, cur_count2);
        end
        step(1, 4'd14);
        tests_run++;
        if (cur_count2 !== 4'd15 || state2 !== 2'd0) begin
            tests_failed++;
            $display("FAIL idle_holds: got cur=%0d st=%0d, expected 15 0", cur_count2, state2);
        end
    endtask

    initial begin
        reset     = 1'b1;
        count_in  = 4'd0;
        count_in2 = 4'd0;
        enable    = 1'b0;
        enable2   = 1'b0;
        err_clr   = 1'b0;
        snap_req  = 1'b0;
        snap_ack  = 1'b0;
        test_reset;
        test_track;
        test_wrap;
        test_glitch_err;
        test_snapshot;
        test_reset_mid;
        test_wrap_ovf;
        test_disable;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 4-bit asynchronous ripple down-counter.
- Brings the counter's unsynchronised, glitch-prone COUNT bus into the clk domain with a 2-flop synchroniser and a stability filter.
- Checks that each accepted value is exactly one decrement from the previous one, counts wrap-arounds (0 -> max) into an extended count, and flags skipped or illegal steps.
- Exposes a req/ack snapshot port so the system reads a coherent {wraps, count} pair.

Parameters:
- WIDTH, 4: width of count_in.
- WRAP_W, 8: width of the wrap-around counter.
- STABLE_CYCLES, 2: consecutive identical synchronised samples needed to accept a value. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- count_in  in  WIDTH  raw ripple-counter output (asynchronous to clk).
- enable  in  1  monitor enable; low forces IDLE.
- err_clr  in  1  clears err and leaves ERR.
- snap_req  in  1  snapshot request.
- snap_ack  in  1  snapshot consumed.
- cur_count  out  WIDTH  last accepted (stable) count.
- wrap_cnt  out  WRAP_W  number of wraps seen since ARM.
- wrap_pulse  out  1  one-cycle pulse on each detected wrap.
- wrap_ovf  out  1  sticky; wrap_cnt saturated.
- err  out  1  sticky; illegal step seen.
- snap_valid  out  1  snapshot holding valid data.
- snap_data  out  WRAP_W+WIDTH  {wrap_cnt, cur_count} captured at request.
- state  out  2  FSM state: IDLE=0, ARM=1, TRACK=2, ERR=3.

Behaviour:
- Reset (async, active-high):
  - All outputs, sync1, sync2 and the stability counter go to 0.
  - state goes to IDLE.
- Synchroniser and stability filter:
  - sync1 <= count_in; sync2 <= sync1.
  - stab_cnt clears when sync2 differs from its previous value; otherwise it increments, saturating at STABLE_CYCLES.
  - A value is "accepted" in the cycle stab_cnt reaches STABLE_CYCLES and sync2 != cur_count. The first acceptance after ARM is accepted even if equal to cur_count.
  - Latency: cur_count updates on the (2+STABLE_CYCLES)th rising clk edge after count_in settles.
- FSM:
  - IDLE: outputs hold. When enable=1, go to ARM.
  - ARM: clear wrap_cnt and wrap_ovf. The first accepted value loads cur_count with no step check, then go to TRACK.
  - TRACK, on each acceptance with prev = cur_count:
    - new == prev-1 (mod 2^WIDTH, excluding the 0 -> max case): legal step; update cur_count.
    - prev == 0 and new == 2^WIDTH-1: wrap. Update cur_count, assert wrap_pulse for one cycle, and increment wrap_cnt, saturating at all ones. When the increment would overflow, wrap_cnt holds and wrap_ovf sets.
    - Any other value: update cur_count, set err, go to ERR.
  - ERR: cur_count keeps tracking accepted values but no step checks run. err_clr=1 clears err and goes to ARM.
  - enable=0 in any state: go to IDLE next cycle. err, wrap_cnt and cur_count are retained.
  - err_clr and an illegal step in the same cycle: the illegal step wins; err stays set.
- Snapshot handshake:
  - When snap_req=1 and snap_valid=0, the next edge captures snap_data={wrap_cnt, cur_count} and sets snap_valid=1.
  - The snapshot captures pre-update values if an acceptance happens in the same cycle.
  - snap_data is held stable while snap_valid=1. snap_req is ignored during that time.
  - snap_valid=1 and snap_ack=1 at an edge: snap_valid clears. A new request is honoured the following cycle, not the same one.
  - snap_ack with snap_valid=0 is ignored.
  - The handshake works in all FSM states.

Optional Feature:
- Macro: RIPPLE_MON_UP_COUNT_EN.
- Defined: the legal step is new == prev+1 and the wrap is prev == 2^WIDTH-1 -> new == 0, for pairing with an up-counter variant.
- Undefined (default): down-count checking exactly as described in Behaviour. All other behaviour is identical in both builds.

Test Plan:
- Reset mid-TRACK with cur_count=9, wrap_cnt=3 -> all outputs 0 and state=IDLE on the same edge, with no clock needed.
- Enable, then drive count_in 5,4,3 with each value held 6 cycles, STABLE_CYCLES=2 -> state ARM then TRACK; cur_count 5,4,3, each updating 4 edges after the input change; err=0.
- Drive count_in 1,0,15,14 -> one wrap_pulse in the cycle 15 is accepted; wrap_cnt=1; err=0.
- Pulse a 1-cycle glitch 0111 between 8 and 7 -> glitch rejected; cur_count goes 8 -> 7; err=0. Then drive 7 -> 4 -> err=1, state=ERR. Pulse err_clr -> state=ARM, err=0.
- With wrap_cnt=2 and cur_count=6, assert snap_req -> snap_valid=1, snap_data=0x026. A wrap then occurs and snap_data stays 0x026. Assert snap_ack -> snap_valid=0. A new request captures 0x03F.
- With WRAP_W=2, produce 4 wraps -> wrap_cnt stays at 3 and wrap_ovf=1 after the 4th wrap.
